cluster_pe_nd: RTL and testbench
================================

Name: cluster_pe_nd

Overview:
- Next-generation k-means cluster processing element for the kd-tree sorting array.
- Generalised to DIM dimensions of DW bits each.
- Accumulates the points assigned to its cluster and computes the new centroid with an on-block sequential divider.
- Flags local stability, and handles parent/child centre swapping during the sort phase.
- One instance sits at each kd-tree node; the tree controller drives its strobes.

Parameters:
DIM, 3, number of dimensions
DW, 8, bits per dimension
MAX_N, 1000, maximum points per cluster per iteration; CW = $clog2(MAX_N+1)
MAX_DEPTH, 16, maximum tree depth; DPW = $clog2(MAX_DEPTH+1)
INIT_CENTER, 0, reset value of centre (DIM*DW bits)
STABLE_TOL, 0, maximum per-dimension |new-old| that still counts as stable

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  global enable; when low, all state including the divider is frozen
init  in  1  centre <= parent_in
load_depth  in  1  depth <= depth_in
depth_in  in  DPW  node depth
start_iter  in  1  begin iteration
receive_point  in  1  point register <= point_in
point_in  in  DIM*DW  broadcast point
inc  in  1  add point register to accumulators
update  in  1  start centroid computation
next_level  in  1  decrement time-to-live
parent_switch  in  1  swap centre with parent
child_switch  in  1  swap centre with child
parent_in  in  DIM*DW  parent centre
child_in  in  DIM*DW  child centre
parent_out  out  DIM*DW  centre handed to parent
child_out  out  DIM*DW  centre handed to child
center_out  out  DIM*DW  current centre
count_out  out  CW  points accumulated
child_depth  out  DPW  depth+1
ce_en  out  1  ttl != 0
busy  out  1  divider running
update_done  out  1  one-cycle pulse when centre is updated
stable  out  1  local stability flag
overflow  out  1  sticky: inc arrived with count == MAX_N

Behaviour:
Reset values:
- center = INIT_CENTER.
- All other registers and outputs 0, including parent_out, child_out, stable, overflow, busy, update_done, depth and ttl.

General:
- All actions are qualified by en.
- rst mid-divide aborts the divide; no update_done is generated.

State machine: IDLE, DIV, DONE.

IDLE, commands evaluated in this order within one cycle:
1. init.
2. load_depth.
3. start_iter: clears accumulators, count, stable and overflow; ttl <= depth.
4. receive_point.
5. inc: acc[d] += point[d] and count += 1. inc in the same cycle as start_iter gives acc = point and count = 1. inc with count == MAX_N leaves acc/count unchanged and sets overflow.
6. next_level: ttl -= 1, saturating at 0.
7. Switch:
   - parent_switch: parent_out <= center, center <= parent_in.
   - Else child_switch: child_out <= center, center <= child_in.
   - parent_switch has priority; init overrides a switch in the same cycle.

inc and receive_point in the same cycle:
- inc uses the old point register.

update in IDLE:
- Enters DIV next cycle.
- The divide uses the accumulators after any same-cycle inc.

DIV:
- busy = 1.
- Restoring divider, one quotient bit per cycle; dimensions processed 0..DIM-1.
- ACC_W = DW + CW cycles per dimension.
- All commands are ignored except rst/en.
- Quotient is truncated, then saturated to 2^DW-1.
- count == 0: skip DIV and go straight to DONE; centre unchanged, stable = 1.

DONE (one cycle):
- update_done = 1.
- center <= quotients.
- stable <= 1 iff every |q[d] - center[d]| <= STABLE_TOL.
- Return to IDLE.

Latency:
- update_done is high exactly DIM*ACC_W + 1 cycles after update is sampled.
- With count == 0, update_done is high 1 cycle after update is sampled.

Optional Feature:
CLUSTER_PE_ROUND_EN:
- Defined: quotient rounded half-up (+1 when 2*remainder >= count), then saturated to 2^DW-1.
- Undefined: quotient truncated.
- Latency is identical in both builds.

Test Plan:
- Reset with INIT_CENTER = 0x0A0B0C -> center_out = 0x0A0B0C; parent_out, child_out, count_out, ce_en, stable, busy all 0.
- init with parent_in = (10,20,30); start_iter; inc points (1,2,3), (3,4,5), (5,6,7); update -> busy for 54 cycles; update_done 55 cycles after update; center = (3,4,5); count_out = 3; stable = 0.
- Points (1,1,1), (2,2,2) then update -> center (1,1,1) without the macro, (2,2,2) with it; a repeat update with unchanged sums -> stable = 1.
- update with count = 0 -> update_done the next cycle; center unchanged; stable = 1. Commands issued during busy -> no effect.
- center A, parent_in B, child_in C, parent_switch and child_switch in the same cycle -> parent_out = A, center = B, child_out unchanged.
- load_depth 2, start_iter -> ce_en = 1, child_depth = 3; next_level x2 -> ce_en = 0; a third next_level keeps ttl at 0.

Source files
------------

// File: rtl/cluster_pe_nd_if.sv
// Command strobes, centre/point buses and status flags of one kd-tree cluster PE.
// The tree controller is the master; the PE is the slave.
interface cluster_pe_nd_if #(
   parameter int DIM       = 3,
   parameter int DW        = 8,
   parameter int MAX_N     = 1000,
   parameter int MAX_DEPTH = 16
);
   localparam int CW  = $clog2(MAX_N + 1);
   localparam int DPW = $clog2(MAX_DEPTH + 1);

   logic              en;
   logic              init;
   logic              load_depth;
   logic              start_iter;
   logic              receive_point;
   logic              inc;
   logic              update;
   logic              next_level;
   logic              parent_switch;
   logic              child_switch;
   logic [DPW-1:0]    depth_in;
   logic [DIM*DW-1:0] point_in;
   logic [DIM*DW-1:0] parent_in;
   logic [DIM*DW-1:0] child_in;
   logic [DIM*DW-1:0] parent_out;
   logic [DIM*DW-1:0] child_out;
   logic [DIM*DW-1:0] center_out;
   logic [CW-1:0]     count_out;
   logic [DPW-1:0]    child_depth;
   logic              ce_en;
   logic              busy;
   logic              update_done;
   logic              stable;
   logic              overflow;

   modport master (
      output en, init, load_depth, start_iter, receive_point, inc, update, next_level,
             parent_switch, child_switch, depth_in, point_in, parent_in, child_in,
      input  parent_out, child_out, center_out, count_out, child_depth, ce_en, busy,
             update_done, stable, overflow
   );

   modport slave (
      input  en, init, load_depth, start_iter, receive_point, inc, update, next_level,
             parent_switch, child_switch, depth_in, point_in, parent_in, child_in,
      output parent_out, child_out, center_out, count_out, child_depth, ce_en, busy,
             update_done, stable, overflow
   );
endinterface

// File: rtl/cluster_pe_nd.sv
// k-means cluster PE: accumulates points, divides sums by count one bit per cycle (CLUSTER_PE_ROUND_EN: round half-up).
// update_done DIM*(DW+CW)+1 cycles after update (1 if count==0); no backpressure, strobes ignored while busy.
module cluster_pe_nd #(
   parameter int                DIM         = 3,
   parameter int                DW          = 8,
   parameter int                MAX_N       = 1000,
   parameter int                MAX_DEPTH   = 16,
   parameter logic [DIM*DW-1:0] INIT_CENTER = '0,
   parameter int                STABLE_TOL  = 0
) (
   input  logic            clk,
   input  logic            rst,
   cluster_pe_nd_if.slave  bus
);
   localparam int CW    = $clog2(MAX_N + 1);
   localparam int DPW   = $clog2(MAX_DEPTH + 1);
   localparam int ACC_W = DW + CW;
   localparam int DIW   = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int BW    = $clog2(ACC_W);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state, state_nxt;

   logic [DIM*DW-1:0] center, parent_out, child_out, point_r, quot_flat;
   logic [DPW-1:0]    depth, ttl, depth_nxt, ttl_nxt;
   logic [ACC_W-1:0]  acc [DIM];
   logic [ACC_W-1:0]  acc_nxt [DIM];
   logic [CW-1:0]     count, count_nxt;
   logic              stable, overflow, ovf_nxt;
   logic [DIW-1:0]    dim_idx;
   logic [BW-1:0]     bit_cnt;
   logic [ACC_W-1:0]  div_rem, div_quo, rem_new, quo_new;
   logic [ACC_W:0]    trial, cnt_ext, q_rnd;
   logic [DW-1:0]     q_sat;
   logic [DW-1:0]     quot [DIM];
   logic              q_bit, last_bit, last_dim, all_close;

   // IDLE command chain in priority order: start_iter clears before a same-cycle inc adds
   always_comb begin
      depth_nxt = bus.load_depth ? bus.depth_in : depth;
      count_nxt = bus.start_iter ? '0 : count;
      ovf_nxt   = bus.start_iter ? 1'b0 : overflow;
      for (int d = 0; d < DIM; d++) acc_nxt[d] = bus.start_iter ? '0 : acc[d];
      if (bus.inc) begin
         if (count_nxt == CW'(MAX_N)) begin
            ovf_nxt = 1'b1;
         end else begin
            for (int d = 0; d < DIM; d++) acc_nxt[d] = acc_nxt[d] + ACC_W'(point_r[d*DW +: DW]);
            count_nxt = count_nxt + 1'b1;
         end
      end
      ttl_nxt = bus.start_iter ? depth_nxt : ttl;
      if (bus.next_level && ttl_nxt != '0) ttl_nxt = ttl_nxt - 1'b1;
   end

   // Restoring divide step: dividend shifts out of div_quo MSB-first as quotient bits shift in
   always_comb begin
      cnt_ext  = (ACC_W+1)'(count);
      trial    = {div_rem, div_quo[ACC_W-1]};
      q_bit    = (trial >= cnt_ext);
      rem_new  = q_bit ? ACC_W'(trial - cnt_ext) : trial[ACC_W-1:0];
      quo_new  = {div_quo[ACC_W-2:0], q_bit};
`ifdef CLUSTER_PE_ROUND_EN
      q_rnd    = {1'b0, quo_new} + (({rem_new, 1'b0} >= cnt_ext) ? (ACC_W+1)'(1) : '0);
`else
      q_rnd    = {1'b0, quo_new};
`endif
      q_sat    = (q_rnd > (ACC_W+1)'({DW{1'b1}})) ? '1 : q_rnd[DW-1:0];
      last_bit = (bit_cnt == BW'(ACC_W - 1));
      last_dim = (dim_idx == DIW'(DIM - 1));
   end

   always_comb begin
      all_close = 1'b1;
      quot_flat = '0;
      for (int d = 0; d < DIM; d++) begin
         quot_flat[d*DW +: DW] = quot[d];
         if (quot[d] > center[d*DW +: DW]) begin
            if (quot[d] - center[d*DW +: DW] > DW'(STABLE_TOL)) all_close = 1'b0;
         end else if (center[d*DW +: DW] - quot[d] > DW'(STABLE_TOL)) begin
            all_close = 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.update) state_nxt = (count_nxt == '0) ? DONE : DIV;
         DIV:     if (last_bit && last_dim) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)         state <= IDLE;
      else if (bus.en) state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         center     <= INIT_CENTER;
         parent_out <= '0;
         child_out  <= '0;
         point_r    <= '0;
         depth      <= '0;
         ttl        <= '0;
         count      <= '0;
         stable     <= 1'b0;
         overflow   <= 1'b0;
         dim_idx    <= '0;
         bit_cnt    <= '0;
         div_rem    <= '0;
         div_quo    <= '0;
         for (int d = 0; d < DIM; d++) begin
            acc[d]  <= '0;
            quot[d] <= '0;
         end
      end else if (bus.en) begin
         case (state)
            IDLE: begin
               depth    <= depth_nxt;
               ttl      <= ttl_nxt;
               count    <= count_nxt;
               overflow <= ovf_nxt;
               for (int d = 0; d < DIM; d++) acc[d] <= acc_nxt[d];
               if (bus.start_iter)    stable  <= 1'b0;
               if (bus.receive_point) point_r <= bus.point_in;
               if (bus.init) begin
                  center <= bus.parent_in;
               end else if (bus.parent_switch) begin
                  parent_out <= center;
                  center     <= bus.parent_in;
               end else if (bus.child_switch) begin
                  child_out <= center;
                  center    <= bus.child_in;
               end
               div_quo <= acc_nxt[0];
               div_rem <= '0;
               dim_idx <= '0;
               bit_cnt <= '0;
            end
            DIV: begin
               if (last_bit) begin
                  quot[dim_idx] <= q_sat;
                  bit_cnt       <= '0;
                  div_rem       <= '0;
                  if (!last_dim) begin
                     dim_idx <= dim_idx + 1'b1;
                     div_quo <= acc[dim_idx + 1'b1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  div_rem <= rem_new;
                  div_quo <= quo_new;
               end
            end
            DONE: begin
               if (count != '0) begin
                  center <= quot_flat;
                  stable <= all_close;
               end else begin
                  stable <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.center_out  = center;
   assign bus.parent_out  = parent_out;
   assign bus.child_out   = child_out;
   assign bus.count_out   = count;
   assign bus.child_depth = depth + 1'b1;
   assign bus.ce_en       = (ttl != '0);
   assign bus.busy        = (state == DIV);
   assign bus.update_done = (state == DONE);
   assign bus.stable      = stable;
   assign bus.overflow    = overflow;
endmodule

// File: tb/tb_cluster_pe_nd.sv
// Directed plus randomized bench for cluster_pe_nd against an arithmetic reference model.
module tb_cluster_pe_nd;
   localparam int DIM = 3, DW = 8, MAX_N = 1000, MAX_DEPTH = 16;
   localparam int CW  = $clog2(MAX_N + 1);
   localparam int DPW = $clog2(MAX_DEPTH + 1);
   localparam int LAT = DIM * (DW + CW) + 1;
   localparam logic [DIM*DW-1:0] INIT = 24'h0A0B0C;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cluster_pe_nd_if #(.DIM(DIM), .DW(DW), .MAX_N(MAX_N), .MAX_DEPTH(MAX_DEPTH)) bus ();

   cluster_pe_nd #(.DIM(DIM), .DW(DW), .MAX_N(MAX_N), .MAX_DEPTH(MAX_DEPTH),
                   .INIT_CENTER(INIT), .STABLE_TOL(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0, errors = 0;
   int m_center[DIM], m_pout[DIM], m_cout[DIM], m_acc[DIM], m_point[DIM];
   int m_cnt, m_depth, m_ttl;
   bit m_stable, m_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DIM*DW-1:0] pack(input int v[DIM]);
      logic [DIM*DW-1:0] r = '0;
      for (int d = 0; d < DIM; d++) r[d*DW +: DW] = DW'(v[d]);
      return r;
   endfunction

   function automatic logic [DIM*DW-1:0] vec(input int a, input int b, input int c);
      int v[DIM];
      v[0] = a; v[1] = b; v[2] = c;
      return pack(v);
   endfunction

   task automatic clear_cmds();
      bus.init = 0; bus.load_depth = 0; bus.start_iter = 0; bus.receive_point = 0;
      bus.inc = 0; bus.update = 0; bus.next_level = 0;
      bus.parent_switch = 0; bus.child_switch = 0;
   endtask

   task automatic model_reset();
      for (int d = 0; d < DIM; d++) begin
         m_center[d] = int'(INIT[d*DW +: DW]);
         m_pout[d] = 0; m_cout[d] = 0; m_acc[d] = 0; m_point[d] = 0;
      end
      m_cnt = 0; m_depth = 0; m_ttl = 0; m_stable = 0; m_ovf = 0;
   endtask

   // Applies one IDLE-cycle worth of strobes, in command order, to the model
   task automatic model_idle();
      int old_pt[DIM], old_c[DIM];
      old_pt = m_point;
      old_c  = m_center;
      if (bus.init) for (int d = 0; d < DIM; d++) m_center[d] = int'(bus.parent_in[d*DW +: DW]);
      if (bus.load_depth) m_depth = int'(bus.depth_in);
      if (bus.start_iter) begin
         for (int d = 0; d < DIM; d++) m_acc[d] = 0;
         m_cnt = 0; m_stable = 0; m_ovf = 0; m_ttl = m_depth;
      end
      if (bus.receive_point) for (int d = 0; d < DIM; d++) m_point[d] = int'(bus.point_in[d*DW +: DW]);
      if (bus.inc) begin
         if (m_cnt == MAX_N) m_ovf = 1;
         else begin
            for (int d = 0; d < DIM; d++) m_acc[d] += old_pt[d];
            m_cnt++;
         end
      end
      if (bus.next_level && m_ttl > 0) m_ttl--;
      if (!bus.init) begin
         if (bus.parent_switch) begin
            m_pout = old_c;
            for (int d = 0; d < DIM; d++) m_center[d] = int'(bus.parent_in[d*DW +: DW]);
         end else if (bus.child_switch) begin
            m_cout = old_c;
            for (int d = 0; d < DIM; d++) m_center[d] = int'(bus.child_in[d*DW +: DW]);
         end
      end
   endtask

   task automatic step();
      if (bus.en) model_idle();
      @(posedge clk); #1;
      clear_cmds();
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":center"},      64'(bus.center_out),  64'(pack(m_center)));
      chk({tag, ":count"},       64'(bus.count_out),   64'(m_cnt));
      chk({tag, ":stable"},      64'(bus.stable),      64'(m_stable));
      chk({tag, ":overflow"},    64'(bus.overflow),    64'(m_ovf));
      chk({tag, ":ce_en"},       64'(bus.ce_en),       64'(m_ttl != 0));
      chk({tag, ":child_depth"}, 64'(bus.child_depth), 64'(DPW'(m_depth + 1)));
      chk({tag, ":parent_out"},  64'(bus.parent_out),  64'(pack(m_pout)));
      chk({tag, ":child_out"},   64'(bus.child_out),   64'(pack(m_cout)));
   endtask

   // Issues update (plus any strobes already set), measures latency/busy, optionally pokes junk while busy
   task automatic do_update(input string tag, input bit junk);
      int q[DIM];
      int lat, done_at, busy_n;
      bit st;
      bus.update = 1;
      model_idle();
      if (m_cnt != 0) begin
         for (int d = 0; d < DIM; d++) begin
            q[d] = m_acc[d] / m_cnt;
`ifdef CLUSTER_PE_ROUND_EN
            if (2 * (m_acc[d] % m_cnt) >= m_cnt) q[d]++;
`endif
            if (q[d] > 255) q[d] = 255;
         end
      end
      lat = (m_cnt == 0) ? 1 : LAT;
      done_at = 0; busy_n = 0;
      @(posedge clk); #1;
      clear_cmds();
      for (int k = 1; k <= lat + 2; k++) begin
         if (bus.update_done && done_at == 0) done_at = k;
         if (bus.busy) busy_n++;
         if (junk && k <= lat) begin
            {bus.init, bus.start_iter, bus.inc, bus.update} = 4'($urandom);
            {bus.parent_switch, bus.child_switch, bus.next_level, bus.load_depth} = 4'($urandom);
            bus.receive_point = 1'($urandom);
            bus.point_in = 24'($urandom);
            bus.parent_in = 24'($urandom);
            bus.child_in = 24'($urandom);
            bus.depth_in = DPW'($urandom);
         end
         @(posedge clk); #1;
         clear_cmds();
      end
      if (m_cnt == 0) m_stable = 1;
      else begin
         st = 1;
         for (int d = 0; d < DIM; d++) if (q[d] != m_center[d]) st = 0;
         m_stable = st;
         m_center = q;
      end
      chk({tag, ":done_latency"}, 64'(done_at), 64'(lat));
      chk({tag, ":busy_cycles"},  64'(busy_n),  64'(lat - 1));
      check_all(tag);
   endtask

   initial begin
      int n, cnt;
      int pts[DIM];
      bus.en = 1; bus.depth_in = '0; bus.point_in = '0; bus.parent_in = '0; bus.child_in = '0;
      clear_cmds();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();

      // reset state
      chk("rst:center",      64'(bus.center_out),  64'(24'h0A0B0C));
      chk("rst:parent_out",  64'(bus.parent_out),  64'(0));
      chk("rst:child_out",   64'(bus.child_out),   64'(0));
      chk("rst:count",       64'(bus.count_out),   64'(0));
      chk("rst:ce_en",       64'(bus.ce_en),       64'(0));
      chk("rst:stable",      64'(bus.stable),      64'(0));
      chk("rst:busy",        64'(bus.busy),        64'(0));
      chk("rst:update_done", 64'(bus.update_done), 64'(0));
      chk("rst:overflow",    64'(bus.overflow),    64'(0));

      // three-point centroid
      bus.parent_in = vec(10, 20, 30); bus.init = 1; step();
      bus.start_iter = 1; step();
      bus.point_in = vec(1, 2, 3); bus.receive_point = 1; step();
      bus.inc = 1; bus.point_in = vec(3, 4, 5); bus.receive_point = 1; step();
      bus.inc = 1; bus.point_in = vec(5, 6, 7); bus.receive_point = 1; step();
      bus.inc = 1; step();
      check_all("acc3");
      do_update("upd3", 0);
      chk("upd3:center_const", 64'(bus.center_out), 64'(vec(3, 4, 5)));
      chk("upd3:count_const",  64'(bus.count_out),  64'(3));
      chk("upd3:stable_const", 64'(bus.stable),     64'(0));

      // rounding case, then repeat update with junk commands during busy
      bus.start_iter = 1; bus.point_in = vec(1, 1, 1); bus.receive_point = 1; step();
      bus.inc = 1; bus.point_in = vec(2, 2, 2); bus.receive_point = 1; step();
      bus.inc = 1; step();
      do_update("round", 0);
`ifdef CLUSTER_PE_ROUND_EN
      chk("round:center_const", 64'(bus.center_out), 64'(vec(2, 2, 2)));
`else
      chk("round:center_const", 64'(bus.center_out), 64'(vec(1, 1, 1)));
`endif
      do_update("repeat_junk", 1);
      chk("repeat:stable_const", 64'(bus.stable), 64'(1));

      // empty cluster
      bus.start_iter = 1; step();
      do_update("zero", 0);
      chk("zero:stable_const", 64'(bus.stable), 64'(1));

      // simultaneous parent/child switch
      bus.parent_in = vec(8'h11, 8'h22, 8'h33); bus.init = 1; step();
      bus.parent_in = vec(8'h44, 8'h55, 8'h66); bus.child_in = vec(8'h77, 8'h88, 8'h99);
      bus.parent_switch = 1; bus.child_switch = 1; step();
      chk("sw:parent_out", 64'(bus.parent_out), 64'(vec(8'h11, 8'h22, 8'h33)));
      chk("sw:center",     64'(bus.center_out), 64'(vec(8'h44, 8'h55, 8'h66)));
      chk("sw:child_out",  64'(bus.child_out),  64'(0));
      bus.child_switch = 1; step();
      chk("csw:child_out", 64'(bus.child_out),  64'(vec(8'h44, 8'h55, 8'h66)));
      check_all("csw");

      // depth / time-to-live
      bus.depth_in = DPW'(2); bus.load_depth = 1; step();
      bus.start_iter = 1; step();
      chk("ttl:ce_en_start",   64'(bus.ce_en),       64'(1));
      chk("ttl:child_depth",   64'(bus.child_depth), 64'(3));
      bus.next_level = 1; step();
      bus.next_level = 1; step();
      chk("ttl:ce_en_zero",    64'(bus.ce_en),       64'(0));
      bus.next_level = 1; step();
      check_all("ttl_sat");

      // enable low freezes everything
      bus.en = 0; bus.point_in = vec(50, 60, 70); bus.receive_point = 1; bus.inc = 1;
      bus.parent_in = vec(1, 1, 1); bus.init = 1; step();
      bus.en = 1;
      check_all("en_low");

      // randomized rounds; final inc coincides with update
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 20);
         for (int d = 0; d < DIM; d++) pts[d] = $urandom_range(0, 255);
         bus.start_iter = 1; bus.point_in = pack(pts); bus.receive_point = 1; step();
         for (int i = 1; i < n; i++) begin
            for (int d = 0; d < DIM; d++) pts[d] = $urandom_range(0, 255);
            bus.inc = 1; bus.point_in = pack(pts); bus.receive_point = 1;
            bus.next_level = 1'($urandom);
            step();
         end
         bus.inc = 1;
         do_update($sformatf("rand%0d", r), r[0]);
      end

      // count saturation at MAX_N
      bus.start_iter = 1; bus.point_in = vec(7, 7, 7); bus.receive_point = 1; step();
      for (int i = 0; i <= MAX_N; i++) begin
         bus.inc = 1; step();
      end
      chk("ovf:count_const", 64'(bus.count_out), 64'(MAX_N));
      chk("ovf:flag_const",  64'(bus.overflow),  64'(1));
      do_update("ovf", 0);
      chk("ovf:center_const", 64'(bus.center_out), 64'(vec(7, 7, 7)));

      // reset mid-divide aborts without update_done
      bus.start_iter = 1; bus.point_in = vec(9, 9, 9); bus.receive_point = 1; step();
      bus.inc = 1; step();
      bus.update = 1; step();
      repeat (10) begin @(posedge clk); #1; end
      rst = 1; @(posedge clk); #1; rst = 0;
      model_reset();
      chk("abort:busy",        64'(bus.busy),        64'(0));
      chk("abort:update_done", 64'(bus.update_done), 64'(0));
      check_all("abort");
      cnt = 0;
      repeat (LAT + 5) begin
         if (bus.update_done) cnt++;
         @(posedge clk); #1;
      end
      chk("abort:late_done", 64'(cnt), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
